gl_fragment_writer: RTL and testbench
=====================================

# gl_fragment_writer

Fragment sink for the rasterizer's pixel output. Accepts `(count_x, count_y)` pixels qualified by `valid_pixel`, back-pressures the rasterizer through `fifo_ready`, buffers fragments in a small FIFO, and drains them as single-word framebuffer writes over a req/ack port. It sits between `gl_rasterizer` and the framebuffer memory controller.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `FB_WIDTH`, 640: framebuffer width in pixels.
- `FB_HEIGHT`, 480: framebuffer height in pixels.
- `ADDR_W`, 19: framebuffer word-address width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `count_x`  in  32  pixel X, unsigned integer, from rasterizer.
- `count_y`  in  32  pixel Y, unsigned integer, from rasterizer.
- `valid_pixel`  in  1  pixel on `count_x`/`count_y` is valid this cycle.
- `color`  in  24  RGB888 fragment colour, sampled with the pixel.
- `fifo_ready`  out  1  rasterizer may present pixels.
- `fb_req`  out  1  write request to framebuffer.
- `fb_addr`  out  ADDR_W  word address, `count_y*FB_WIDTH + count_x`.
- `fb_data`  out  24  write data.
- `fb_ack`  in  1  framebuffer accepted current request.
- `idle`  out  1  FIFO empty and no `valid_pixel` this cycle.
- `overflow`  out  1  sticky: a pixel arrived while the FIFO was full.

## Operation
- Push: on a rising edge with `valid_pixel=1` and the FIFO not full, store `{addr, color}`. Address computed at push, truncated to ADDR_W.
- Pop: on a rising edge with `fb_req=1` and `fb_ack=1`.
- Push and pop in the same cycle: both occur; occupancy is unchanged. This is legal even when full, because the pop frees the slot first.
- `valid_pixel` while full with no pop: pixel dropped, `overflow` set. `overflow` clears only on `rst`.
- `fb_req` = FIFO not empty. `fb_addr`/`fb_data` show the head entry and hold stable while `fb_req=1` and `fb_ack=0`.
- `fifo_ready` registered: next value = 1 iff occupancy after this edge is at most DEPTH-2. This leaves one slot of slack for the pixel the rasterizer emits in the cycle `fifo_ready` falls.
- Pointers are log2(DEPTH) bits wide plus one wrap bit. Full = indices equal with wrap bits differing. Empty = fully equal. Pointers wrap modulo DEPTH.
- `fb_ack` while `fb_req=0` is ignored.

## Timing
- Reset values: `fifo_ready=1`, `fb_req=0`, `fb_addr=0`, `fb_data=0`, `idle=1`, `overflow=0`. Pointers and occupancy are 0.
- Latency: a pixel pushed at edge N into an empty FIFO gives `fb_req=1` with its address after edge N, visible in cycle N+1.
- Throughput: one push and one pop per cycle.
- `fifo_ready` deasserts the cycle after occupancy reaches DEPTH-1. It reasserts the cycle after occupancy drops to DEPTH-2 or less.
- Reset mid-operation: all buffered fragments are discarded immediately and `fb_req` drops asynchronously. A write in flight (req=1, ack pending) is abandoned; the framebuffer side must tolerate this.
- `idle` is combinational: `empty & ~valid_pixel`.

## Configuration
- `GL_FRAG_CLIP_EN` defined:
  - A pixel with `count_x >= FB_WIDTH` or `count_y >= FB_HEIGHT` is silently discarded at push.
  - A discarded pixel is never stored, never sets `overflow`, and does not occupy a slot.
- Not defined:
  - Every valid pixel is stored.
  - The address is `count_y*FB_WIDTH + count_x` truncated to ADDR_W, so out-of-range pixels alias.

## Test plan
- Reset, `fb_ack` tied 1, push (1,1) colour 0xFF0000: `fb_req` high in the next cycle with `fb_addr=641`, `fb_data=0xFF0000`, then low. `idle` returns to 1.
- `fb_ack` held 0, push 15 consecutive pixels (x=0..14, y=2):
  - `fifo_ready` falls after the 15th push.
  - A 16th pixel is accepted and `overflow` stays 0.
  - A 17th pixel is dropped and `overflow`=1.
  - `fb_addr` holds 1280 throughout.
- FIFO full, `valid_pixel=1` and `fb_ack=1` in the same cycle: occupancy stays 16, both pixels appear in order, `overflow` stays 0.
- With `GL_FRAG_CLIP_EN`, push (640,0), (0,480), (639,479): only `fb_addr=307199` is issued.
- Without the macro, the same stimulus issues addresses 640, 307200, and 307199, in that order.
- Fill 8 entries, assert `rst` mid-drain with `fb_req=1`:
  - `fb_req=0` immediately, `fifo_ready=1`.
  - After release, a new pixel (2,0) is the first write, with `fb_addr=2`.

Source files
------------

// File: rtl/gl_fragment_writer_if.sv
// Pixel-in / framebuffer-write bundle for gl_fragment_writer.
// master = rasterizer + framebuffer side (drives pixels and ack),
// slave  = fragment writer (drives ready, requests and status).
interface gl_fragment_writer_if #(
  parameter int ADDR_W = 19
);
  // rasterizer -> writer
  logic [31:0]       count_x;
  logic [31:0]       count_y;
  logic              valid_pixel;
  logic [23:0]       color;
  logic              fifo_ready;
  // writer -> framebuffer
  logic              fb_req;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;
  logic              fb_ack;
  // status
  logic              idle;
  logic              overflow;

  modport master (
    output count_x, count_y, valid_pixel, color, fb_ack,
    input  fifo_ready, fb_req, fb_addr, fb_data, idle, overflow
  );

  modport slave (
    input  count_x, count_y, valid_pixel, color, fb_ack,
    output fifo_ready, fb_req, fb_addr, fb_data, idle, overflow
  );
endinterface

// File: rtl/gl_fragment_writer.sv
// Fragment sink: buffers rasterizer pixels {addr,color} and drains them as framebuffer writes.
// Latency: pixel pushed at edge N into an empty FIFO is requested in cycle N+1; 1 push + 1 pop per cycle.
// Backpressure: registered fifo_ready drops once occupancy > DEPTH-2; pixels arriving when full are dropped
// and latch overflow. Optional clipping of off-screen pixels is enabled by defining GL_FRAG_CLIP_EN.
module gl_fragment_writer #(
  parameter int DEPTH     = 16,
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int ADDR_W    = 19
) (
  input logic clk,
  input logic rst,
  gl_fragment_writer_if.slave px
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ADDR_W + 24;

`ifdef GL_FRAG_CLIP_EN
  // Off-screen pixels are discarded before they reach the FIFO.
  localparam bit CLIP_EN = 1'b1;
`else
  // Every valid pixel is stored; off-screen coordinates alias after truncation.
  localparam bit CLIP_EN = 1'b0;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];
  logic                 fifo_ready_q, fifo_ready_d;
  logic                 overflow_q, overflow_d;

  logic [PTR_W-1:0]     wr_idx;
  logic [PTR_W-1:0]     rd_idx;
  logic                 empty;
  logic                 full;
  logic [PTR_W:0]       occ;
  logic [PTR_W:0]       occ_next;
  logic [63:0]          addr_wide;
  logic [ADDR_W-1:0]    push_addr;
  logic                 in_range;
  logic                 discard;
  logic                 pop;
  logic                 push;
  logic [ENTRY_W-1:0]   head;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign occ    = wr_ptr_q - rd_ptr_q;
  assign head   = mem_q[rd_idx];

  // Address and clip decision for the pixel currently on the input.
  always_comb begin
    addr_wide = 64'(px.count_y) * 64'(FB_WIDTH) + 64'(px.count_x);
    push_addr = addr_wide[ADDR_W-1:0];
    in_range  = (px.count_x < 32'(FB_WIDTH)) && (px.count_y < 32'(FB_HEIGHT));
    discard   = CLIP_EN && !in_range;
  end

  // Push/pop qualification; a pop in the same cycle frees a slot for a push into a full FIFO.
  always_comb begin
    pop  = !empty && px.fb_ack;
    push = px.valid_pixel && !discard && (!full || pop);
  end

  // Next pointers, storage, ready and sticky overflow.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    overflow_d   = overflow_q;
    occ_next     = occ;
    if (push) begin
      mem_d[wr_idx] = {push_addr, px.color};
      wr_ptr_d      = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      occ_next = occ + 1'b1;
    end else if (pop && !push) begin
      occ_next = occ - 1'b1;
    end
    if (px.valid_pixel && !discard && full && !pop) begin
      overflow_d = 1'b1;
    end
    // Keep one slot spare for the pixel issued in the cycle ready falls.
    fifo_ready_d = (occ_next <= (PTR_W+1)'(DEPTH - 2));
  end

  // Control state: cleared asynchronously so requests drop the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_ready_q <= fifo_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  // Entry storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs: head entry shown while requesting, zero otherwise.
  always_comb begin
    px.fb_req     = !empty;
    px.fb_addr    = empty ? '0 : head[ENTRY_W-1:24];
    px.fb_data    = empty ? '0 : head[23:0];
    px.fifo_ready = fifo_ready_q;
    px.overflow   = overflow_q;
    px.idle       = empty && !px.valid_pixel;
  end

endmodule

// File: tb/tb_gl_fragment_writer.sv
// Randomized bench for gl_fragment_writer against a queue-based reference model,
// plus directed scenarios with hand-computed expected addresses.
module tb_gl_fragment_writer;
  localparam int DEPTH = 16;
  localparam int FBW   = 640;
  localparam int FBH   = 480;
  localparam int AW    = 19;
`ifdef GL_FRAG_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gl_fragment_writer_if #(.ADDR_W(AW)) bus ();

  gl_fragment_writer #(
    .DEPTH(DEPTH), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .px (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {addr,color}.
  logic [AW+23:0] mq[$];
  bit             movf = 1'b0;
  bit             mrdy = 1'b1;
  logic [AW-1:0]  wlog[$];

  function automatic logic [AW-1:0] addr_of(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] a;
    a = {32'd0, y} * 64'(FBW) + {32'd0, x};
    a = a % (64'd1 << AW);
    return a[AW-1:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      movf = 1'b0;
      mrdy = 1'b1;
    end else begin
      bit do_pop, is_full, keep, do_push;
      do_pop  = (mq.size() > 0) && bus.fb_ack;
      is_full = (mq.size() == DEPTH);
      keep    = bus.valid_pixel &&
                !(CLIP && (bus.count_x >= 32'(FBW) || bus.count_y >= 32'(FBH)));
      do_push = keep && (!is_full || do_pop);
      if (keep && is_full && !do_pop) movf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({addr_of(bus.count_x, bus.count_y), bus.color});
      mrdy = (mq.size() <= DEPTH - 2);
    end
  end

  // Compare every cycle mid-period; also log every accepted write.
  always @(negedge clk) begin
    logic [AW+23:0] h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check("fb_req",     bus.fb_req,     64'(mq.size() != 0));
    check("fb_addr",    bus.fb_addr,    64'(h[AW+23:24]));
    check("fb_data",    bus.fb_data,    64'(h[23:0]));
    check("fifo_ready", bus.fifo_ready, 64'(mrdy));
    check("overflow",   bus.overflow,   64'(movf));
    check("idle",       bus.idle,       64'((mq.size() == 0) && !bus.valid_pixel));
    if (bus.fb_req && bus.fb_ack) wlog.push_back(bus.fb_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [23:0] c,
                       input logic v, input logic a);
    bus.count_x     = x;
    bus.count_y     = y;
    bus.color       = c;
    bus.valid_pixel = v;
    bus.fb_ack      = a;
  endtask

  task automatic do_reset();
    bus.valid_pixel = 1'b0;
    bus.fb_ack      = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int ackpct;

  initial begin
    drive(0, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("rst_ready", bus.fifo_ready, 1);
    check("rst_req",   bus.fb_req,     0);
    check("rst_addr",  bus.fb_addr,    0);
    check("rst_idle",  bus.idle,       1);
    check("rst_ovf",   bus.overflow,   0);
    step();
    rst = 1'b0;

    // Single pixel, ack tied high.
    do_reset();
    drive(1, 1, 24'hFF0000, 1'b1, 1'b1);
    step();
    bus.valid_pixel = 1'b0;
    @(negedge clk);
    check("t1_req",  bus.fb_req,  1);
    check("t1_addr", bus.fb_addr, 641);
    check("t1_data", bus.fb_data, 24'hFF0000);
    step();
    @(negedge clk);
    check("t1_req_low", bus.fb_req, 0);
    check("t1_idle",    bus.idle,   1);
    step();

    // Fill with ack low: ready falls after 15th push, 16th accepted, 17th dropped.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(i, 2, 24'(i), 1'b1, 1'b0);
      step();
      if (i == 13) check("t2_ready_14", bus.fifo_ready, 1);
    end
    check("t2_ready_15", bus.fifo_ready, 0);
    check("t2_addr_15",  bus.fb_addr,    1280);
    drive(15, 2, 24'd15, 1'b1, 1'b0);
    step();
    check("t2_ovf_16",  bus.overflow, 0);
    drive(16, 2, 24'd16, 1'b1, 1'b0);
    step();
    check("t2_ovf_17",  bus.overflow, 1);
    check("t2_addr_17", bus.fb_addr,  1280);
    bus.valid_pixel = 1'b0;
    step();

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(i, 2, 24'(i), 1'b1, 1'b0);
      step();
    end
    check("t3_full_ovf", bus.overflow, 0);
    wlog.delete();
    drive(20, 2, 24'hABCDEF, 1'b1, 1'b1);
    step();
    check("t3_ready", bus.fifo_ready, 0);
    check("t3_ovf",   bus.overflow,   0);
    bus.valid_pixel = 1'b0;
    repeat (20) step();
    check("t3_count", wlog.size(), 17);
    check("t3_first", wlog[0],  1280);
    check("t3_15",    wlog[15], 1295);
    check("t3_last",  wlog[16], 1300);

    // Boundary coordinates.
    do_reset();
    wlog.delete();
    drive(640, 0,   24'h000001, 1'b1, 1'b1); step();
    drive(0,   480, 24'h000002, 1'b1, 1'b1); step();
    drive(639, 479, 24'h000003, 1'b1, 1'b1); step();
    bus.valid_pixel = 1'b0;
    repeat (5) step();
`ifdef GL_FRAG_CLIP_EN
    check("t4_count", wlog.size(), 1);
    check("t4_a0",    wlog[0], 307199);
`else
    check("t4_count", wlog.size(), 3);
    check("t4_a0",    wlog[0], 640);
    check("t4_a1",    wlog[1], 307200);
    check("t4_a2",    wlog[2], 307199);
`endif

    // Reset mid-drain.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i, 3, 24'(i + 100), 1'b1, 1'b0);
      step();
    end
    bus.valid_pixel = 1'b0;
    bus.fb_ack      = 1'b1;
    step();
    step();
    check("t5_req_before", bus.fb_req, 1);
    rst = 1'b1;
    #1;
    check("t5_req_async",   bus.fb_req,     0);
    check("t5_ready_async", bus.fifo_ready, 1);
    step();
    rst = 1'b0;
    wlog.delete();
    drive(2, 0, 24'h123456, 1'b1, 1'b1);
    step();
    bus.valid_pixel = 1'b0;
    repeat (4) step();
    check("t5_count", wlog.size(), 1);
    check("t5_addr",  wlog[0], 2);

    // Randomized traffic with varying drain rate.
    do_reset();
    ackpct = 50;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rx, ry;
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       ackpct = 5;
          1:       ackpct = 50;
          default: ackpct = 95;
        endcase
      end
      if ($urandom_range(0, 19) == 0) begin
        rx = $urandom();
        ry = $urandom();
      end else begin
        rx = $urandom_range(0, 700);
        ry = $urandom_range(0, 500);
      end
      drive(rx, ry, 24'($urandom()), 1'($urandom_range(0, 99) < 70),
            1'($urandom_range(0, 99) < ackpct));
      step();
    end
    bus.valid_pixel = 1'b0;
    bus.fb_ack      = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
